// File: rtl/fifo_read_checker.sv
// fifo_read_checker
// -----------------
// Reads a run of words from a FIFO and checks them against an incrementing
// sequence that starts at a given seed. Each word is compared on the cycle
// after its read request. The block counts words and mismatches, and keeps
// the expected and actual value of the first mismatch.
//
// Optional feature: define FIFO_READ_CHECKER_THROTTLE_EN to add a 16-bit
// LFSR. It randomly blocks read requests during RUN. The port list is the
// same either way.
//
// Parameters
//   BITS    : FIFO entry width
//   COUNT_W : width of the word counters
//
// Ports
//   read_clk        : clock; all logic runs on its rising edge
//   read_rst        : synchronous active-high reset
//   start           : one-cycle run request (accepted in IDLE or DONE)
//   num_words       : words to consume, sampled on the accepted start
//   seed            : first expected word, sampled on the accepted start
//   p_read_en       : FIFO read request (combinational)
//   p_read_data     : FIFO read data, valid one cycle after a read
//   p_read_empty    : FIFO empty flag
//   busy            : high in RUN or FLUSH
//   done            : level, high in DONE
//   pass            : done with no mismatches
//   rx_count        : words compared this run
//   error_count     : mismatches this run, saturating
//   first_err_valid : a mismatch has been captured this run
//   first_err_exp   : expected word of the first mismatch
//   first_err_act   : actual word of the first mismatch
module fifo_read_checker #(
    parameter int BITS    = 32,
    parameter int COUNT_W = 16
) (
    input  logic               read_clk,
    input  logic               read_rst,
    input  logic               start,
    input  logic [COUNT_W-1:0] num_words,
    input  logic [BITS-1:0]    seed,
    output logic               p_read_en,
    input  logic [BITS-1:0]    p_read_data,
    input  logic               p_read_empty,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [COUNT_W-1:0] rx_count,
    output logic [COUNT_W-1:0] error_count,
    output logic               first_err_valid,
    output logic [BITS-1:0]    first_err_exp,
    output logic [BITS-1:0]    first_err_act
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] num_words_q, num_words_d;
    logic [COUNT_W-1:0] issued_q, issued_d;
    logic [COUNT_W-1:0] rx_count_q, rx_count_d;
    logic [COUNT_W-1:0] error_count_q, error_count_d;
    logic [BITS-1:0]    expected_q, expected_d;
    logic [BITS-1:0]    first_err_exp_q, first_err_exp_d;
    logic [BITS-1:0]    first_err_act_q, first_err_act_d;
    logic               first_err_valid_q, first_err_valid_d;
    logic               rvalid_q, rvalid_d;
    logic               gate_ok;
    logic               read_en;

`ifdef FIFO_READ_CHECKER_THROTTLE_EN
    logic [15:0] lfsr_q, lfsr_d;

    // Read requests are blocked on roughly one RUN cycle in four.
    assign gate_ok = (lfsr_q[1:0] != 2'b00);

    always_comb begin
        lfsr_d = lfsr_q;
        if ((state_q == IDLE || state_q == DONE) && start) begin
            lfsr_d = 16'hACE1;
        end else if (state_q == RUN) begin
            // Fibonacci form, taps 16,14,13,11
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge read_clk) begin
        if (read_rst) begin
            lfsr_q <= '0;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign gate_ok = 1'b1;
`endif

    // The reset term blocks a read in the same cycle that reset is asserted.
    assign read_en = (state_q == RUN) && !p_read_empty && (issued_q < num_words_q)
                     && !read_rst && gate_ok;

    always_comb begin
        state_d           = state_q;
        num_words_d       = num_words_q;
        issued_d          = issued_q;
        rx_count_d        = rx_count_q;
        error_count_d     = error_count_q;
        expected_d        = expected_q;
        first_err_exp_d   = first_err_exp_q;
        first_err_act_d   = first_err_act_q;
        first_err_valid_d = first_err_valid_q;
        rvalid_d          = read_en;

        if (read_en) begin
            issued_d = issued_q + COUNT_W'(1);
        end

        if (rvalid_q) begin
            rx_count_d = rx_count_q + COUNT_W'(1);
            expected_d = expected_q + BITS'(1);
            if (p_read_data != expected_q) begin
                if (error_count_q != '1) begin
                    error_count_d = error_count_q + COUNT_W'(1);
                end
                if (!first_err_valid_q) begin
                    first_err_valid_d = 1'b1;
                    first_err_exp_d   = expected_q;
                    first_err_act_d   = p_read_data;
                end
            end
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    num_words_d       = num_words;
                    expected_d        = seed;
                    issued_d          = '0;
                    rx_count_d        = '0;
                    error_count_d     = '0;
                    first_err_valid_d = 1'b0;
                    first_err_exp_d   = '0;
                    first_err_act_d   = '0;
                    state_d           = (num_words == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (read_en && (issued_q + COUNT_W'(1) == num_words_q)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // The last read was issued on the previous cycle, so its
                // compare always happens here.
                if (rvalid_q && (rx_count_q + COUNT_W'(1) == num_words_q)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge read_clk) begin
        if (read_rst) begin
            state_q           <= IDLE;
            num_words_q       <= '0;
            issued_q          <= '0;
            rx_count_q        <= '0;
            error_count_q     <= '0;
            expected_q        <= '0;
            first_err_exp_q   <= '0;
            first_err_act_q   <= '0;
            first_err_valid_q <= 1'b0;
            rvalid_q          <= 1'b0;
        end else begin
            state_q           <= state_d;
            num_words_q       <= num_words_d;
            issued_q          <= issued_d;
            rx_count_q        <= rx_count_d;
            error_count_q     <= error_count_d;
            expected_q        <= expected_d;
            first_err_exp_q   <= first_err_exp_d;
            first_err_act_q   <= first_err_act_d;
            first_err_valid_q <= first_err_valid_d;
            rvalid_q          <= rvalid_d;
        end
    end

    assign p_read_en       = read_en;
    assign busy            = (state_q == RUN) || (state_q == FLUSH);
    assign done            = (state_q == DONE);
    assign pass            = (state_q == DONE) && (error_count_q == '0);
    assign rx_count        = rx_count_q;
    assign error_count     = error_count_q;
    assign first_err_valid = first_err_valid_q;
    assign first_err_exp   = first_err_exp_q;
    assign first_err_act   = first_err_act_q;

endmodule

// File: tb/tb_fifo_read_checker.sv
module tb_fifo_read_checker;

    localparam int BITS    = 32;
    localparam int COUNT_W = 16;

    logic               read_clk;
    logic               read_rst;
    logic               start;
    logic [COUNT_W-1:0] num_words;
    logic [BITS-1:0]    seed;
    logic               p_read_en;
    logic [BITS-1:0]    p_read_data;
    logic               p_read_empty;
    logic               busy;
    logic               done;
    logic               pass;
    logic [COUNT_W-1:0] rx_count;
    logic [COUNT_W-1:0] error_count;
    logic               first_err_valid;
    logic [BITS-1:0]    first_err_exp;
    logic [BITS-1:0]    first_err_act;

    fifo_read_checker #(.BITS(BITS), .COUNT_W(COUNT_W)) dut (
        .read_clk        (read_clk),
        .read_rst        (read_rst),
        .start           (start),
        .num_words       (num_words),
        .seed            (seed),
        .p_read_en       (p_read_en),
        .p_read_data     (p_read_data),
        .p_read_empty    (p_read_empty),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .rx_count        (rx_count),
        .error_count     (error_count),
        .first_err_valid (first_err_valid),
        .first_err_exp   (first_err_exp),
        .first_err_act   (first_err_act)
    );

    initial read_clk = 1'b0;
    always #5 read_clk = ~read_clk;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // FIFO model contents and bookkeeping
    logic [BITS-1:0] mem [16];
    int unsigned     fill;
    int unsigned     rd_ptr;
    logic            gap;
    logic            force_full;
    logic            last_en;
    int unsigned     reads;
    int unsigned     empty_viol;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive the empty flag at the falling edge, sample the
    // combinational read request, then return read data just after the edge.
    task automatic step();
        @(negedge read_clk);
        p_read_empty = force_full ? 1'b0 : (gap || (rd_ptr >= fill));
        #1;
        last_en = p_read_en;
        if (last_en && p_read_empty) empty_viol++;
        if (last_en) reads++;
        @(posedge read_clk);
        #1;
        if (last_en) begin
            p_read_data = (rd_ptr < 16) ? mem[rd_ptr] : '0;
            rd_ptr++;
        end
    endtask

    task automatic load(input logic [BITS-1:0] base, input int unsigned n);
        for (int unsigned i = 0; i < 16; i++) mem[i] = base + BITS'(i);
        fill       = n;
        rd_ptr     = 0;
        reads      = 0;
        empty_viol = 0;
    endtask

    task automatic kick(input logic [BITS-1:0] s, input logic [COUNT_W-1:0] n);
        seed      = s;
        num_words = n;
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic wait_done();
        int unsigned cyc;
        cyc = 0;
        while (!done && cyc < 200) begin
            step();
            cyc++;
        end
        check_eq("done_timeout", {63'd0, done}, 64'd1);
    endtask

    int unsigned r0;

    initial begin
        read_rst     = 1'b1;
        start        = 1'b0;
        num_words    = '0;
        seed         = '0;
        p_read_data  = '0;
        p_read_empty = 1'b0;
        gap          = 1'b0;
        force_full   = 1'b1;
        load('0, 8);

        // Reset held for 3 cycles with a non-empty FIFO
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("rst_read_en", {63'd0, last_en}, 64'd0);
        end
        read_rst   = 1'b0;
        force_full = 1'b0;
        step();
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_done", {63'd0, done}, 64'd0);
        check_eq("rst_pass", {63'd0, pass}, 64'd0);
        check_eq("rst_rx", 64'(rx_count), 64'd0);
        check_eq("rst_err", 64'(error_count), 64'd0);
        check_eq("rst_fev", {63'd0, first_err_valid}, 64'd0);

        // Clean run: 0x10..0x17
        load(32'h10, 8);
        kick(32'h10, 16'd8);
        check_eq("clean_busy", {63'd0, busy}, 64'd1);
        wait_done();
        check_eq("clean_pass", {63'd0, pass}, 64'd1);
        check_eq("clean_rx", 64'(rx_count), 64'd8);
        check_eq("clean_err", 64'(error_count), 64'd0);
        check_eq("clean_reads", 64'(reads), 64'd8);
        check_eq("clean_fev", {63'd0, first_err_valid}, 64'd0);
        repeat (3) step();
        check_eq("clean_hold_rx", 64'(rx_count), 64'd8);
        check_eq("clean_hold_done", {63'd0, done}, 64'd1);

        // Mismatch: data 0,1,5,3 against expected 0,1,2,3
        load(32'h0, 4);
        mem[2] = 32'h5;
        kick(32'h0, 16'd4);
        wait_done();
        check_eq("mm_err", 64'(error_count), 64'd1);
        check_eq("mm_fev", {63'd0, first_err_valid}, 64'd1);
        check_eq("mm_exp", 64'(first_err_exp), 64'd2);
        check_eq("mm_act", 64'(first_err_act), 64'd5);
        check_eq("mm_pass", {63'd0, pass}, 64'd0);
        check_eq("mm_rx", 64'(rx_count), 64'd4);

        // Wrap of the expected word from all-ones to zero
        load(32'hFFFF_FFFE, 4);
        kick(32'hFFFF_FFFE, 16'd4);
        wait_done();
        check_eq("wrap_pass", {63'd0, pass}, 64'd1);
        check_eq("wrap_err", 64'(error_count), 64'd0);
        check_eq("wrap_fev", {63'd0, first_err_valid}, 64'd0);

        // Empty gap mid-run, then reset in FLUSH, then a zero-length run
        load(32'h100, 10);
        kick(32'h100, 16'd10);
        repeat (2) step();
        gap = 1'b1;
        r0  = reads;
        repeat (5) step();
        check_eq("gap_reads", 64'(reads - r0), 64'd0);
        check_eq("gap_viol", 64'(empty_viol), 64'd0);
        check_eq("gap_busy", {63'd0, busy}, 64'd1);
        gap = 1'b0;
        r0  = 0;
        while (reads < 10 && r0 < 200) begin
            step();
            r0++;
        end
        check_eq("gap_total_reads", 64'(reads), 64'd10);
        check_eq("flush_busy", {63'd0, busy}, 64'd1);
        check_eq("flush_done", {63'd0, done}, 64'd0);
        read_rst = 1'b1;
        step();
        read_rst = 1'b0;
        check_eq("rstf_busy", {63'd0, busy}, 64'd0);
        check_eq("rstf_done", {63'd0, done}, 64'd0);
        check_eq("rstf_rx", 64'(rx_count), 64'd0);
        step();
        check_eq("rstf_rx_after", 64'(rx_count), 64'd0);
        check_eq("rstf_idle_busy", {63'd0, busy}, 64'd0);
        r0 = reads;
        kick(32'h55, 16'd0);
        check_eq("zero_done", {63'd0, done}, 64'd1);
        check_eq("zero_pass", {63'd0, pass}, 64'd1);
        check_eq("zero_rx", 64'(rx_count), 64'd0);
        check_eq("zero_busy", {63'd0, busy}, 64'd0);
        check_eq("zero_reads", 64'(reads - r0), 64'd0);
        check_eq("all_viol", 64'(empty_viol), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/fifo_read_checker.md
FIFO_READ_CHECKER -- requirements
Module: fifo_read_checker

Interface
REQ-001 SHALL have parameter BITS, default 32, FIFO entry width.
REQ-002 SHALL have parameter COUNT_W, default 16, width of word counters.
REQ-003 SHALL have port read_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port read_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle run request.
REQ-006 SHALL have port num_words  input  COUNT_W  words to consume in the run, sampled on the accepted start.
REQ-007 SHALL have port seed  input  BITS  first expected word, sampled on the accepted start.
REQ-008 SHALL have port p_read_en  output  1  FIFO read request.
REQ-009 SHALL have port p_read_data  input  BITS  FIFO read data, valid one cycle after an accepted read.
REQ-010 SHALL have port p_read_empty  input  1  FIFO empty flag.
REQ-011 SHALL have port busy  output  1  high in RUN or FLUSH.
REQ-012 SHALL have port done  output  1  level, high in DONE.
REQ-013 SHALL have port pass  output  1  done and error_count==0.
REQ-014 SHALL have port rx_count  output  COUNT_W  words compared this run.
REQ-015 SHALL have port error_count  output  COUNT_W  mismatches this run, saturating at all-ones.
REQ-016 SHALL have port first_err_valid  output  1  a mismatch has been captured this run.
REQ-017 SHALL have ports first_err_exp and first_err_act  output  BITS each  expected and actual word of the first mismatch.

Function
REQ-018 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-019 SHALL, in IDLE or DONE on start=1, latch num_words and seed, clear all counters and first_err_*, and go to RUN; if num_words==0, go directly to DONE.
REQ-020 SHALL ignore start in RUN and FLUSH.
REQ-021 SHALL drive p_read_en = RUN && !p_read_empty && issued<num_words && !read_rst, combinationally; never high while p_read_empty=1.
REQ-022 SHALL count each cycle with p_read_en=1 as one issued read, with a registered rvalid set in the following cycle.
REQ-023 SHALL, on rvalid, compare p_read_data to expected, increment rx_count, then set expected to expected+1 modulo 2^BITS (wrap from all-ones to 0).
REQ-024 SHALL, on a mismatch, increment error_count, saturating at 2^COUNT_W-1; if first_err_valid=0, capture expected/actual and set first_err_valid.
REQ-025 SHALL go RUN->FLUSH on the cycle the last read is issued, and FLUSH->DONE on the cycle the last rvalid is compared.
REQ-026 SHALL hold rx_count, error_count and first_err_* stable in DONE until the next accepted start.
REQ-027 SHALL tolerate p_read_empty toggling every cycle with no lost or duplicated compare.

Reset
REQ-028 SHALL, while read_rst=1, force p_read_en=0 in the same cycle.
REQ-029 SHALL, on a clock edge with read_rst=1, enter IDLE and clear rvalid, all counters, first_err_* and latched values to 0, so busy, done, pass and first_err_valid are 0.
REQ-030 SHALL abandon a run on reset mid-RUN/FLUSH, discarding any in-flight rvalid.

Configuration
REQ-031 SHALL, with macro FIFO_READ_CHECKER_THROTTLE_EN defined, run a 16-bit Fibonacci LFSR (taps 16,14,13,11) loaded with 0xACE1 on an accepted start and stepped every RUN cycle, and additionally gate p_read_en to 0 when LFSR[1:0]==2'b00.
REQ-032 SHALL, without FIFO_READ_CHECKER_THROTTLE_EN, contain no LFSR; the port list is identical either way.

Verification
REQ-033 Reset: read_rst high 3 cycles, p_read_empty=0 -> p_read_en=0 throughout; outputs 0 after release.
REQ-034 Clean run: seed=0x10, num_words=8, FIFO holds 0x10..0x17 -> done=1, pass=1, rx_count=8, error_count=0, exactly 8 read cycles.
REQ-035 Mismatch: seed=0, num_words=4, data 0,1,5,3 -> error_count=1, first_err_exp=2, first_err_act=5, pass=0.
REQ-036 Wrap: seed=0xFFFFFFFE, num_words=4, data FFFFFFFE,FFFFFFFF,0,1 -> pass=1.
REQ-037 Empty gaps and restart: empty high for 5 cycles mid-run, then reset mid-FLUSH, then new start with num_words=0 -> no read while empty, IDLE after reset, done next cycle with rx_count=0.
